uart_echo_bridge: RTL and testbench

Parametrised FIFO-to-FIFO mover between the UART receive interface's read port and the UART transmit interface's write port. It pops one word at a time, applies an optional per-word transform selected at run time, waits for transmit-FIFO space and pushes the result. It supports configurable data width, configurable source read latency and run-time enable, and reports a running count of written words.

---
 rtl/uart_echo_bridge_if.sv | 30 +++
 rtl/uart_echo_bridge.sv | 146 ++++++++++++++
 tb/tb_uart_echo_bridge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_echo_bridge_if.sv
// FIFO-side bundle for uart_echo_bridge: RX FIFO read port and TX FIFO write port.
// The master modport is the bridge; the slave modport is the FIFO pair.
interface uart_echo_bridge_if #(
    parameter int DATA_W = 8
) ();
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              full;

    modport master (
        output rd_req,
        input  rd_data,
        input  empty,
        output wr_req,
        output wr_data,
        input  full
    );

    modport slave (
        input  rd_req,
        output rd_data,
        output empty,
        input  wr_req,
        input  wr_data,
        output full
    );
endinterface

// File: rtl/uart_echo_bridge.sv
// Moves words from the RX FIFO to the TX FIFO one at a time with an optional byte transform.
// Define UART_ECHO_CRLF_EN to append 0x0A after every written 0x0D.
//
// state      | meaning
// S_IDLE     | waiting for enable=1 and a non-empty RX FIFO
// S_READ     | rd_req pulse, load latency counter
// S_WAIT     | wait for RX read data, capture and transform on terminal count
// S_SPACE    | hold word until the TX FIFO has room
// S_WRITE    | wr_req pulse, count the word
// S_LF_SPACE | (CRLF build) wait for room for the inserted line feed
// S_LF_WRITE | (CRLF build) wr_req pulse carrying 0x0A
module uart_echo_bridge #(
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic [1:0]           mode_i,
    uart_echo_bridge_if.master   bus,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     word_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SPACE,
        S_WRITE
`ifdef UART_ECHO_CRLF_EN
        ,
        S_LF_SPACE,
        S_LF_WRITE
`endif
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY);

    state_t             state_q, state_d;
    logic [2:0]         lat_q, lat_d;
    logic               rd_req_q, rd_req_d;
    logic               wr_req_q, wr_req_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

    function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] m);
        logic [7:0] r;
        r = b;
        case (m)
            2'd1: if (b >= 8'h61 && b <= 8'h7A) r = b - 8'h20;
            2'd2: if (b >= 8'h41 && b <= 8'h5A) r = b + 8'h20;
            2'd3: r = ~b;
            default: r = b;
        endcase
        return r;
    endfunction

    // Outputs are registered from the next-state decision so each strobe lines up with its state.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        rd_req_d   = 1'b0;
        wr_req_d   = 1'b0;
        wr_data_d  = wr_data_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (enable_i && !bus.empty) begin
                    state_d  = S_READ;
                    rd_req_d = 1'b1;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
                lat_d   = LAT_INIT;
            end
            S_WAIT: begin
                if (lat_q == 3'd1) begin
                    wr_data_d      = bus.rd_data;
                    wr_data_d[7:0] = xform(bus.rd_data[7:0], mode_i);
                    state_d        = S_SPACE;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            S_SPACE: begin
                if (!bus.full) begin
                    state_d    = S_WRITE;
                    wr_req_d   = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
`ifdef UART_ECHO_CRLF_EN
                if (wr_data_q[7:0] == 8'h0D) state_d = S_LF_SPACE;
                else                          state_d = S_IDLE;
`else
                state_d = S_IDLE;
`endif
            end
`ifdef UART_ECHO_CRLF_EN
            S_LF_SPACE: begin
                if (!bus.full) begin
                    state_d    = S_LF_WRITE;
                    wr_req_d   = 1'b1;
                    wr_data_d  = DATA_W'(8'h0A);
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            S_LF_WRITE: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lat_q      <= '0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            rd_req_q   <= rd_req_d;
            wr_req_q   <= wr_req_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign bus.rd_req  = rd_req_q;
    assign bus.wr_req  = wr_req_q;
    assign bus.wr_data = wr_data_q;
    assign busy_o      = busy_q;
    assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_uart_echo_bridge.sv
// Scoreboard bench for uart_echo_bridge: RX FIFO model feeds words, a monitor checks every TX write.
// Expected words and counts follow the UART_ECHO_CRLF_EN setting of the build.
module tb_uart_echo_bridge;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic        busy;
    logic [15:0] word_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] exp_q[$];

    uart_echo_bridge_if #(.DATA_W(DW)) ifc ();

    uart_echo_bridge #(.DATA_W(DW), .READ_LATENCY(1), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_i   (enable),
        .mode_i     (mode),
        .bus        (ifc),
        .busy_o     (busy),
        .word_cnt_o (word_cnt)
    );

    always #5 clk = ~clk;

    // RX FIFO model: one-cycle read latency
    always @(posedge clk) begin
        if (ifc.rd_req && rx_q.size() > 0) ifc.rd_data <= rx_q.pop_front();
    end

    always @(negedge clk) ifc.empty = (rx_q.size() == 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifc.wr_req === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_wr_req", {24'd0, ifc.wr_data}, 32'hFFFF_FFFF);
            else                   chk("wr_data", {24'd0, ifc.wr_data}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(busy == 1'b0 && exp_q.size() == 0) && n < 300) begin
            cyc(1);
            n++;
        end
        if (n >= 300) chk({name, "_timeout"}, 32'(n), 32'd0);
    endtask

    task automatic wait_rd(input string name);
        int n = 0;
        while (ifc.rd_req !== 1'b1 && n < 40) begin
            cyc(1);
            n++;
        end
        if (n >= 40) chk({name, "_rd_timeout"}, 32'(n), 32'd0);
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] e);
        rx_q.push_back(d);
        exp_q.push_back(e);
    endtask

    initial begin
        int cnt;
        int bad;
        rst_n      = 1'b0;
        enable     = 1'b1;
        mode       = 2'd0;
        ifc.full   = 1'b0;
        push(8'h41, 8'h41);
        cyc(4);
        chk("rst_rd_req",  {31'd0, ifc.rd_req}, 32'd0);
        chk("rst_wr_req",  {31'd0, ifc.wr_req}, 32'd0);
        chk("rst_wr_data", {24'd0, ifc.wr_data}, 32'd0);
        chk("rst_busy",    {31'd0, busy}, 32'd0);
        chk("rst_word_cnt", {16'd0, word_cnt}, 32'd0);

        // Latency: IDLE decides at the first edge, rd_req after it, wr_req after the fourth.
        rst_n = 1'b1;
        cyc(1);
        chk("lat_rd_req_e1", {31'd0, ifc.rd_req}, 32'd1);
        cyc(1);
        chk("lat_rd_req_e2", {31'd0, ifc.rd_req}, 32'd0);
        cyc(1);
        chk("lat_wr_req_e3", {31'd0, ifc.wr_req}, 32'd0);
        cyc(1);
        chk("lat_wr_req_e4", {31'd0, ifc.wr_req}, 32'd1);
        cyc(1);
        chk("lat_word_cnt", {16'd0, word_cnt}, 32'd1);
        wait_idle("lat");

        mode = 2'd1;
        push(8'h61, 8'h41); push(8'h7A, 8'h5A); push(8'h5B, 8'h5B); push(8'h41, 8'h41);
        wait_idle("mode1");
        mode = 2'd3;
        push(8'h61, 8'h9E); push(8'h7A, 8'h85); push(8'h5B, 8'hA4); push(8'h41, 8'hBE);
        wait_idle("mode3");
        mode = 2'd2;
        push(8'h41, 8'h61); push(8'h5A, 8'h7A); push(8'h40, 8'h40); push(8'h5B, 8'h5B);
        wait_idle("mode2");
        chk("cnt_after_modes", {16'd0, word_cnt}, 32'd13);

        // Backpressure
        mode     = 2'd0;
        ifc.full = 1'b1;
        push(8'h33, 8'h33);
        cyc(8);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (ifc.wr_req !== 1'b0 || ifc.wr_data !== 8'h33) bad++;
            cyc(1);
        end
        chk("bp_hold", 32'(bad), 32'd0);
        ifc.full = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (ifc.wr_req === 1'b1) cnt++;
        end
        chk("bp_one_write", 32'(cnt), 32'd1);
        wait_idle("bp");

        // Enable drop during WAIT
        push(8'h55, 8'h55);
        rx_q.push_back(8'h66);
        wait_rd("en");
        cyc(1);
        enable = 1'b0;
        wait_idle("en");
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1);
            if (ifc.rd_req === 1'b1) cnt++;
        end
        chk("en_no_rd_req", 32'(cnt), 32'd0);
        chk("en_rx_left", 32'(rx_q.size()), 32'd1);
        chk("en_word_cnt", {16'd0, word_cnt}, 32'd15);
        rx_q.delete();
        cyc(2);
        enable = 1'b1;
        cyc(2);

        // Reset during SPACE
        ifc.full = 1'b1;
        rx_q.push_back(8'h77);
        wait_rd("rst");
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_req",  {31'd0, ifc.wr_req}, 32'd0);
        chk("midrst_wr_data", {24'd0, ifc.wr_data}, 32'd0);
        chk("midrst_busy",    {31'd0, busy}, 32'd0);
        chk("midrst_word_cnt", {16'd0, word_cnt}, 32'd0);
        ifc.full = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (ifc.wr_req === 1'b1) cnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (ifc.wr_req === 1'b1) cnt++;
        end
        chk("midrst_no_write", 32'(cnt), 32'd0);

        // CR handling
        rx_q.push_back(8'h0D);
        rx_q.push_back(8'h31);
        exp_q.push_back(8'h0D);
`ifdef UART_ECHO_CRLF_EN
        exp_q.push_back(8'h0A);
`endif
        exp_q.push_back(8'h31);
        wait_idle("crlf");
`ifdef UART_ECHO_CRLF_EN
        chk("crlf_word_cnt", {16'd0, word_cnt}, 32'd3);
`else
        chk("crlf_word_cnt", {16'd0, word_cnt}, 32'd2);
`endif
        cyc(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
